// File: rtl/bram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module      : bram_dp_clr
// Description : Simple-dual-port block RAM, one write port and one read port
//               on a single clock. Per-lane write masks, concurrent read and
//               write, read-valid strobe with optional output register, and a
//               self-clearing sweep after reset that zeroes every word before
//               traffic is accepted.
//
// Parameters  : memSize_p   - address width, depth = 2**memSize_p words
//               dataWidth_p - word width (integer multiple of byteWidth_p)
//               byteWidth_p - bits per write-mask lane
//               outReg_p    - 0: read latency 1, 1: read latency 2
//
// Ports       : clk_i    - clock, rising edge
//               rst_i    - asynchronous active-high reset
//               write_i  - write request
//               wmask_i  - per-lane write enable
//               waddr_i  - write address
//               data_i   - write data
//               read_i   - read request
//               raddr_i  - read address
//               data_o   - read data, held between reads
//               valid_o  - one-cycle strobe, data_o valid in same cycle
//               ready_o  - high once the clear sweep has completed
//
// Macro       : BRAM_DP_CLR_FWD_EN - when defined, a same-address same-cycle
//               read and write returns the newly written lanes (write-first).
//               When undefined, collisions are read-first.
//
// Revision    : 1.0 - initial release
// ============================================================================
module bram_dp_clr #(
    parameter int memSize_p   = 8,
    parameter int dataWidth_p = 16,
    parameter int byteWidth_p = 8,
    parameter int outReg_p    = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               write_i,
    input  logic [dataWidth_p/byteWidth_p-1:0] wmask_i,
    input  logic [memSize_p-1:0]               waddr_i,
    input  logic [dataWidth_p-1:0]             data_i,
    input  logic                               read_i,
    input  logic [memSize_p-1:0]               raddr_i,
    output logic [dataWidth_p-1:0]             data_o,
    output logic                               valid_o,
    output logic                               ready_o
);

    localparam int c_LANES = dataWidth_p / byteWidth_p;
    localparam int c_DEPTH = 2 ** memSize_p;
    // Terminal sweep address, expressed at the counter width.
    localparam logic [memSize_p:0] c_LAST_ADDR = {1'b0, {memSize_p{1'b1}}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [memSize_p:0]       r_clr_cnt;
    logic                     w_run;
    logic                     w_clr_last;

    logic [dataWidth_p-1:0]   r_mem [0:c_DEPTH-1];

    logic [c_LANES-1:0]       w_we;
    logic [memSize_p-1:0]     w_waddr;
    logic [dataWidth_p-1:0]   w_wdata;

    logic                     w_rd_en;
    logic [dataWidth_p-1:0]   w_rd_word;

    logic [dataWidth_p-1:0]   r_data;
    logic                     r_valid;

    assign w_run      = (r_state == ST_RUN);
    assign w_clr_last = (r_clr_cnt == c_LAST_ADDR);
    assign w_rd_en    = w_run && read_i;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_clr_last) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // Sweep counter advances once per clear write and freezes in RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_clr_cnt <= '0;
        end else if (!w_run) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write port: the sweep owns the port until ready, user traffic after.
    // ------------------------------------------------------------------
    always_comb begin
        w_we    = '0;
        w_waddr = waddr_i;
        w_wdata = data_i;
        if (!w_run) begin
            w_we    = '1;
            w_waddr = r_clr_cnt[memSize_p-1:0];
            w_wdata = '0;
        end else if (write_i) begin
            w_we    = wmask_i;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int n = 0; n < c_LANES; n++) begin
            if (w_we[n]) begin
                r_mem[w_waddr][n*byteWidth_p +: byteWidth_p] <= w_wdata[n*byteWidth_p +: byteWidth_p];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port. The array is sampled before this edge's write lands, so a
    // collision naturally returns the old word unless forwarding is built.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_word = r_mem[raddr_i];
`ifdef BRAM_DP_CLR_FWD_EN
        if (w_run && write_i && (waddr_i == raddr_i)) begin
            for (int n = 0; n < c_LANES; n++) begin
                if (wmask_i[n]) begin
                    w_rd_word[n*byteWidth_p +: byteWidth_p] = data_i[n*byteWidth_p +: byteWidth_p];
                end
            end
        end
`endif
    end

    generate
        if (outReg_p != 0) begin : g_out_reg
            logic [dataWidth_p-1:0] r_stage;
            logic                   r_stage_vld;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_stage     <= '0;
                    r_stage_vld <= 1'b0;
                    r_data      <= '0;
                    r_valid     <= 1'b0;
                end else begin
                    r_stage_vld <= w_rd_en;
                    if (w_rd_en) r_stage <= w_rd_word;
                    r_valid     <= r_stage_vld;
                    if (r_stage_vld) r_data <= r_stage;
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_rd_en;
                    if (w_rd_en) r_data <= w_rd_word;
                end
            end
        end
    endgenerate

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign ready_o = w_run;

endmodule
`default_nettype wire

// File: tb/tb_bram_dp_clr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_dp_clr
// Description : Self-checking bench for bram_dp_clr. Two instances share the
//               stimulus: one with read latency 1 and one with the output
//               register (latency 2), whose expected stream is the latency-1
//               stream delayed by one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_dp_clr;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic [1:0]  wmask;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    logic        read;
    logic [7:0]  raddr;

    logic [15:0] d0, d1;
    logic        v0, v1, r0, r1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bram_dp_clr #(.memSize_p(8), .dataWidth_p(16), .byteWidth_p(8), .outReg_p(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .write_i(write), .wmask_i(wmask), .waddr_i(waddr),
        .data_i(wdata), .read_i(read), .raddr_i(raddr),
        .data_o(d0), .valid_o(v0), .ready_o(r0)
    );

    bram_dp_clr #(.memSize_p(8), .dataWidth_p(16), .byteWidth_p(8), .outReg_p(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .write_i(write), .wmask_i(wmask), .waddr_i(waddr),
        .data_i(wdata), .read_i(read), .raddr_i(raddr),
        .data_o(d1), .valid_o(v1), .ready_o(r1)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  mask;
        logic [7:0]  wa;
        logic [15:0] wd;
        logic        rd;
        logic [7:0]  ra;
        logic        ev;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic wr, input logic [1:0] mask, input logic [7:0] wa,
                       input logic [15:0] wd, input logic rd, input logic [7:0] ra,
                       input logic ev, input logic [15:0] ed);
        vec_t v;
        v.wr = wr; v.mask = mask; v.wa = wa; v.wd = wd;
        v.rd = rd; v.ra = ra; v.ev = ev; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic idle();
        write = 1'b0; wmask = 2'b00; waddr = 8'h00; wdata = 16'h0000;
        read  = 1'b0; raddr = 8'h00;
    endtask

    // Runs a full sweep from reset release, checking ready timing and that
    // no read (read_i may be held high) produces a valid strobe meanwhile.
    task automatic sweep(input string tag);
        int early = 0;
        int vhits = 0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i < 256 && (r0 || r1)) early++;
            if (v0 || v1) vhits++;
        end
        chk({tag, "_ready_early"}, early, 0);
        chk({tag, "_valid_in_clear"}, vhits, 0);
        chk({tag, "_ready0_256"}, r0, 1);
        chk({tag, "_ready1_256"}, r1, 1);
    endtask

    initial begin
        logic [15:0] coll_exp;
        logic        pv;
        logic [15:0] pd;
        int          vhits;

`ifdef BRAM_DP_CLR_FWD_EN
        coll_exp = 16'h2211;
`else
        coll_exp = 16'h1111;
`endif
        //   wr  mask   waddr  wdata     rd  raddr  ev  ed
        add(0, 2'b00, 8'h00, 16'h0000, 1, 8'h00, 1, 16'h0000);
        add(0, 2'b00, 8'h00, 16'h0000, 1, 8'h7F, 1, 16'h0000);
        add(0, 2'b00, 8'h00, 16'h0000, 1, 8'hFF, 1, 16'h0000);
        add(1, 2'b11, 8'h10, 16'hBEEF, 0, 8'h00, 0, 16'h0000);
        add(1, 2'b01, 8'h10, 16'h1234, 0, 8'h00, 0, 16'h0000);
        add(0, 2'b00, 8'h00, 16'h0000, 1, 8'h10, 1, 16'hBE34);
        add(1, 2'b11, 8'h21, 16'h5555, 0, 8'h00, 0, 16'hBE34);
        add(1, 2'b11, 8'h20, 16'hAAAA, 1, 8'h21, 1, 16'h5555);
        add(0, 2'b00, 8'h00, 16'h0000, 1, 8'h20, 1, 16'hAAAA);
        add(1, 2'b11, 8'h30, 16'h1111, 0, 8'h00, 0, 16'hAAAA);
        add(1, 2'b10, 8'h30, 16'h2222, 1, 8'h30, 1, coll_exp);
        add(0, 2'b00, 8'h00, 16'h0000, 1, 8'h30, 1, 16'h2211);
        add(1, 2'b11, 8'h01, 16'h000A, 0, 8'h00, 0, 16'h2211);
        add(1, 2'b11, 8'h02, 16'h000B, 0, 8'h00, 0, 16'h2211);
        add(1, 2'b11, 8'h03, 16'h000C, 0, 8'h00, 0, 16'h2211);
        add(0, 2'b00, 8'h00, 16'h0000, 1, 8'h01, 1, 16'h000A);
        add(0, 2'b00, 8'h00, 16'h0000, 1, 8'h02, 1, 16'h000B);
        add(0, 2'b00, 8'h00, 16'h0000, 1, 8'h03, 1, 16'h000C);
        add(0, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 16'h000C);
        add(1, 2'b00, 8'h50, 16'h9999, 0, 8'h00, 0, 16'h000C);
        add(0, 2'b00, 8'h00, 16'h0000, 1, 8'h50, 1, 16'h0000);
        add(1, 2'b11, 8'h40, 16'h7777, 0, 8'h00, 0, 16'h0000);

        // Reset state
        rst = 1'b1;
        idle();
        #12;
        chk("rst_data0", d0, 0);
        chk("rst_valid0", v0, 0);
        chk("rst_ready0", r0, 0);
        chk("rst_data1", d1, 0);
        chk("rst_valid1", v1, 0);
        chk("rst_ready1", r1, 0);
        tick();
        rst = 1'b0;
        sweep("sweep1");

        // Table-driven traffic; the latency-2 instance trails by one row.
        pv = 1'b0;
        pd = 16'h0000;
        foreach (tbl[i]) begin
            write = tbl[i].wr; wmask = tbl[i].mask; waddr = tbl[i].wa; wdata = tbl[i].wd;
            read  = tbl[i].rd; raddr = tbl[i].ra;
            tick();
            chk($sformatf("row%0d_valid0", i), v0, tbl[i].ev);
            chk($sformatf("row%0d_data0", i), d0, tbl[i].ed);
            chk($sformatf("row%0d_valid1", i), v1, pv);
            chk($sformatf("row%0d_data1", i), d1, pd);
            pv = tbl[i].ev;
            pd = tbl[i].ed;
        end
        idle();
        tick();
        chk("flush_valid0", v0, 0);
        chk("flush_data0_hold", d0, pd);
        chk("flush_valid1", v1, pv);
        chk("flush_data1", d1, pd);

        // Reset while running with a read in flight
        read = 1'b1; raddr = 8'h40;
        tick();
        chk("pre_rst_data0", d0, 16'h7777);
        chk("pre_rst_valid0", v0, 1);
        rst = 1'b1;
        idle();
        #2;
        chk("async_ready0", r0, 0);
        chk("async_valid0", v0, 0);
        chk("async_data0", d0, 0);
        chk("async_ready1", r1, 0);
        chk("async_valid1", v1, 0);
        tick();
        rst = 1'b0;
        // Second sweep, interrupted at clear counter 100; reads held high.
        read = 1'b1; raddr = 8'h40;
        vhits = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (v0 || v1 || r0 || r1) vhits++;
        end
        chk("sweep2_quiet", vhits, 0);
        rst = 1'b1;
        #2;
        chk("midclr_ready0", r0, 0);
        chk("midclr_valid0", v0, 0);
        tick();
        rst = 1'b0;
        sweep("sweep3");

        // Post-sweep: load a non-zero result first so a zero read is meaningful.
        idle();
        write = 1'b1; wmask = 2'b11; waddr = 8'h41; wdata = 16'h0F0F;
        tick();
        idle();
        read = 1'b1; raddr = 8'h41;
        tick();
        chk("post_0x41_data0", d0, 16'h0F0F);
        raddr = 8'h40;
        tick();
        chk("post_0x40_valid0", v0, 1);
        chk("post_0x40_data0", d0, 16'h0000);
        chk("post_0x41_data1", d1, 16'h0F0F);
        idle();
        tick();
        chk("post_0x40_valid1", v1, 1);
        chk("post_0x40_data1", d1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
